// File: rtl/clkdiv_ctrl.sv
// Run/stop toggle clock divider; clk_out and tick are registered, first edge D cycles after start.
// Divisor offers stall (cfg_ready low) while one divisor is queued, until it is applied at a full-period end.
module clkdiv_ctrl #(
    parameter int CNT_W       = 19,
    parameter int DEFAULT_DIV = 250000,
    parameter int MIN_DIV     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] active_div
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] LIM_DIV = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic [CNT_W-1:0] active_div_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_div_nxt;
    logic             pend_valid;
    logic             pend_valid_nxt;
    logic             clk_out_nxt;
    logic             tick_nxt;
    logic             cfg_err_nxt;
    logic             stop_exit;
    logic             boundary;
    logic             cfg_fire;
    logic             cfg_legal;

    assign cfg_ready = !pend_valid;
    assign cfg_fire  = cfg_valid && !pend_valid;
    assign cfg_legal = (cfg_div >= LIM_DIV);
    assign boundary  = (counter == active_div - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        counter_nxt    = counter;
        clk_out_nxt    = clk_out;
        tick_nxt       = 1'b0;
        cfg_err_nxt    = 1'b0;
        active_div_nxt = active_div;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;
        stop_exit      = 1'b0;

        case (state)
            IDLE: begin
                counter_nxt = '0;
                clk_out_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    counter_nxt = '0;
                    clk_out_nxt = !clk_out;
                    tick_nxt    = 1'b1;
                    // A falling edge closes a full period: the only safe point to swap divisors.
                    if (clk_out && pend_valid) begin
                        active_div_nxt = pend_div;
                        pend_valid_nxt = 1'b0;
                    end
                end else begin
                    counter_nxt = counter + ONE;
                end
                if (stop) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (boundary) begin
                    counter_nxt = '0;
                    stop_exit   = 1'b1;
                    state_nxt   = IDLE;
                    if (clk_out) begin
                        clk_out_nxt = 1'b0;
                        tick_nxt    = 1'b1;
                    end
                    if (pend_valid) begin
                        active_div_nxt = pend_div;
                        pend_valid_nxt = 1'b0;
                    end
                end else begin
                    counter_nxt = counter + ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // An offer landing on the stop-exit edge goes straight to active_div so it cannot strand in IDLE.
        if (cfg_fire) begin
            if (!cfg_legal) begin
                cfg_err_nxt = 1'b1;
            end else if (state == IDLE || stop_exit) begin
                active_div_nxt = cfg_div;
            end else begin
                pend_div_nxt   = cfg_div;
                pend_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
            active_div <= DEF_DIV;
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else begin
            counter    <= counter_nxt;
            clk_out    <= clk_out_nxt;
            tick       <= tick_nxt;
            cfg_err    <= cfg_err_nxt;
            busy       <= (state_nxt != IDLE);
            active_div <= active_div_nxt;
            pend_div   <= pend_div_nxt;
            pend_valid <= pend_valid_nxt;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: event-level reference model of divider edges, stop and divisor queueing.
module tb_clkdiv_ctrl;

    localparam int CNT_W   = 19;
    localparam int DEF_DIV = 24;
    localparam int MIN_DIV = 2;
    localparam int MAXN    = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] active_div;

    int errors = 0;
    int checks = 0;

    // Per-cycle signature {clk_out, tick, busy, cfg_ready, cfg_err}
    logic [4:0]       exp_sig [0:MAXN-1];
    logic [CNT_W-1:0] exp_div [0:MAXN-1];
    logic [4:0]       obs_sig [0:MAXN-1];
    logic [CNT_W-1:0] obs_div [0:MAXN-1];

    clkdiv_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF_DIV),
        .MIN_DIV    (MIN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .active_div(active_div)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Index n = state after the n-th edge following the start edge. Boundaries are scheduled as
    // absolute edge numbers (previous boundary + divisor); no counter is modelled.
    task automatic build_model(input int d1, input int d2, input int n_off, input int n_stop, input int nn);
        int  lvl, div, nb, pdiv;
        bit  pend, pend_prev, stopping, idle, tk, er;
        lvl = 0; div = d1; nb = d1; pdiv = 0;
        pend = 0; stopping = 0; idle = 0;
        exp_sig[0] = 5'b00110;
        exp_div[0] = CNT_W'(d1);
        for (int n = 1; n <= nn; n++) begin
            tk = 0; er = 0;
            pend_prev = pend;
            if (!idle && n == nb) begin
                if (stopping) begin
                    if (lvl == 1) begin
                        lvl = 0;
                        tk  = 1;
                    end
                    idle = 1;
                    if (pend) begin
                        div = pdiv; pend = 0;
                    end
                end else begin
                    lvl = 1 - lvl;
                    tk  = 1;
                    if (lvl == 0 && pend) begin
                        div = pdiv; pend = 0;
                    end
                end
                nb = n + div;
            end
            if (!idle && n == n_stop) stopping = 1;
            if (n == n_off && !pend_prev) begin
                if (d2 < MIN_DIV) er = 1;
                else if (idle) div = d2;
                else begin
                    pdiv = d2; pend = 1;
                end
            end
            exp_sig[n] = {lvl[0], tk, !idle, !pend, er};
            exp_div[n] = CNT_W'(div);
        end
    endtask

    task automatic set_div(input int d);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(d);
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    task automatic run_window(input int d2, input int n_off, input int n_stop, input bit both, input int nn);
        start = 1'b1;
        step();
        start = 1'b0;
        obs_sig[0] = {clk_out, tick, busy, cfg_ready, cfg_err};
        obs_div[0] = active_div;
        for (int n = 1; n <= nn; n++) begin
            cfg_valid = (n == n_off);
            cfg_div   = CNT_W'(d2);
            stop      = (n == n_stop);
            start     = both && (n == n_stop);
            step();
            cfg_valid = 1'b0;
            stop      = 1'b0;
            start     = 1'b0;
            obs_sig[n] = {clk_out, tick, busy, cfg_ready, cfg_err};
            obs_div[n] = active_div;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step(); step();
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got=%b want=0", clk_out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
        checks++; if (active_div !== CNT_W'(DEF_DIV)) begin errors++; $display("FAIL reset_active_div got=%0d want=%0d", active_div, DEF_DIV); end
        rst = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin errors++; $display("FAIL idle_stop_ignored got busy=%b clk_out=%b want 0 0", busy, clk_out); end
    endtask

    task automatic test_default_run();
        build_model(DEF_DIV, 0, 0, 60, 110);
        run_window(0, 0, 60, 1'b0, 110);
        for (int n = 0; n <= 110; n++) begin
            checks++;
            if (obs_sig[n] !== exp_sig[n] || obs_div[n] !== exp_div[n]) begin
                errors++;
                $display("FAIL default_run n=%0d got sig=%b div=%0d want sig=%b div=%0d", n, obs_sig[n], obs_div[n], exp_sig[n], exp_div[n]);
            end
        end
    endtask

    task automatic test_idle_config();
        set_div(4);
        checks++; if (active_div !== CNT_W'(4)) begin errors++; $display("FAIL idle_cfg_apply got=%0d want=4", active_div); end
        build_model(4, 0, 0, 40, 50);
        run_window(0, 0, 40, 1'b0, 50);
        for (int n = 0; n <= 50; n++) begin
            checks++;
            if (obs_sig[n] !== exp_sig[n] || obs_div[n] !== exp_div[n]) begin
                errors++;
                $display("FAIL idle_config n=%0d got sig=%b div=%0d want sig=%b div=%0d", n, obs_sig[n], obs_div[n], exp_sig[n], exp_div[n]);
            end
        end
    endtask

    task automatic test_midrun_change();
        set_div(4);
        build_model(4, 6, 6, 40, 60);
        run_window(6, 6, 40, 1'b0, 60);
        for (int n = 0; n <= 60; n++) begin
            checks++;
            if (obs_sig[n] !== exp_sig[n] || obs_div[n] !== exp_div[n]) begin
                errors++;
                $display("FAIL midrun_change n=%0d got sig=%b div=%0d want sig=%b div=%0d", n, obs_sig[n], obs_div[n], exp_sig[n], exp_div[n]);
            end
        end
    endtask

    task automatic test_illegal_div();
        set_div(4);
        build_model(4, 1, 9, 30, 40);
        run_window(1, 9, 30, 1'b0, 40);
        for (int n = 0; n <= 40; n++) begin
            checks++;
            if (obs_sig[n] !== exp_sig[n] || obs_div[n] !== exp_div[n]) begin
                errors++;
                $display("FAIL illegal_div n=%0d got sig=%b div=%0d want sig=%b div=%0d", n, obs_sig[n], obs_div[n], exp_sig[n], exp_div[n]);
            end
        end
    endtask

    // Table: {stop edge, start-with-stop, offer edge, offered divisor}
    task automatic test_stop_cases();
        int tbl [0:3][0:3];
        tbl[0] = '{5, 0, 0, 0};    // stop while clk_out high
        tbl[1] = '{9, 0, 0, 0};    // stop while clk_out low
        tbl[2] = '{6, 1, 0, 0};    // start and stop together
        tbl[3] = '{10, 0, 10, 7};  // offer together with stop
        for (int t = 0; t < 4; t++) begin
            set_div(4);
            build_model(4, tbl[t][3], tbl[t][2], tbl[t][0], 24);
            run_window(tbl[t][3], tbl[t][2], tbl[t][0], tbl[t][1] != 0, 24);
            for (int n = 0; n <= 24; n++) begin
                checks++;
                if (obs_sig[n] !== exp_sig[n] || obs_div[n] !== exp_div[n]) begin
                    errors++;
                    $display("FAIL stop_case%0d n=%0d got sig=%b div=%0d want sig=%b div=%0d", t, n, obs_sig[n], obs_div[n], exp_sig[n], exp_div[n]);
                end
            end
        end
    endtask

    task automatic test_random();
        int d1, d2, n_off, n_stop;
        bit both;
        for (int it = 0; it < 10; it++) begin
            d1     = $urandom_range(9, 2);
            d2     = $urandom_range(9, 0);
            n_off  = $urandom_range(50, 1);
            n_stop = $urandom_range(60, 1);
            both   = 1'($urandom_range(1, 0));
            set_div(d1);
            build_model(d1, d2, n_off, n_stop, 80);
            run_window(d2, n_off, n_stop, both, 80);
            for (int n = 0; n <= 80; n++) begin
                checks++;
                if (obs_sig[n] !== exp_sig[n] || obs_div[n] !== exp_div[n]) begin
                    errors++;
                    $display("FAIL random it=%0d d1=%0d d2=%0d off=%0d stop=%0d n=%0d got sig=%b div=%0d want sig=%b div=%0d",
                             it, d1, d2, n_off, n_stop, n, obs_sig[n], obs_div[n], exp_sig[n], exp_div[n]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_div(4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            cfg_valid = (n == 6);
            cfg_div   = CNT_W'(6);
            step();
            cfg_valid = 1'b0;
        end
        checks++; if (cfg_ready !== 1'b0 || clk_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre got ready=%b clk_out=%b want 0 1", cfg_ready, clk_out); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rstmid_clk_out got=%b want=0", clk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (active_div !== CNT_W'(DEF_DIV)) begin errors++; $display("FAIL rstmid_active_div got=%0d want=%0d", active_div, DEF_DIV); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cfg_ready got=%b want=1", cfg_ready); end
        for (int n = 0; n < 6; n++) step();
        checks++; if (clk_out !== 1'b0 || busy !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL rstmid_idle got clk_out=%b busy=%b tick=%b want 0 0 0", clk_out, busy, tick); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_idle_config();
        test_midrun_change();
        test_illegal_div();
        test_stop_cases();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
